fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined RV32I core. Holds the fetch PC, issues single-outstanding requests to instruction memory over a request/grant/response handshake, and delivers fetched words through the IF/ID register to the decode stage and main decoder. Honours decode stall, decode flush and execute-stage redirects (branch/JAL/JALR). Inserts an all-zero bubble that the decoder maps to no side effects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- XLEN, 32, address/instruction width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- StallD  in  1  decode cannot accept; IF/ID holds
- FlushD  in  1  clear IF/ID to bubble
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  XLEN  redirect target; bits [1:0] ignored
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (= PCF)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  XLEN  response instruction word
- InstrD  out  XLEN  instruction to decode
- PCD  out  XLEN  PC of InstrD
- PCPlus4D  out  XLEN  PCD + 4
- ValidD  out  1  InstrD is a real instruction
- FetchBusyF  out  1  request outstanding (state WAIT)

## Operation
- State: PCF, FSM {REQ, WAIT, HOLD}, kill flag, hold buffer (instr, pc).
- REQ: imem_req=1, imem_addr=PCF; on imem_gnt -> WAIT.
- WAIT: imem_req=0. On imem_rvalid: kill set -> discard, clear kill, -> REQ. Otherwise, if !StallD, load IF/ID {imem_rdata, PCF, PCF+4, ValidD=1}, PCF<=PCF+4, -> REQ. If StallD, capture in hold buffer, -> HOLD.
- HOLD: when !StallD, move buffer to IF/ID, PCF<=PCF+4, -> REQ.
- IF/ID with !StallD and nothing delivered this cycle: InstrD<=0, ValidD<=0 (bubble; opcode 7'b0000000).
- FlushD: IF/ID <= bubble, PCD/PCPlus4D <= 0; overrides StallD and any same-cycle delivery. The delivered word is lost only if PCSrcE also set; otherwise it is kept (HOLD) and delivered later.
- PCSrcE (highest priority): PCF <= {PCTargetE[XLEN-1:2],2'b00}. In REQ with imem_gnt same cycle -> WAIT with kill set. In WAIT without rvalid -> kill set. In WAIT with rvalid -> data discarded, -> REQ. In HOLD -> buffer dropped, -> REQ. No instruction is delivered in a PCSrcE cycle.
- Ungranted request may change address after a redirect; granted requests are never retracted.
- PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
- rst: FSM -> REQ, PCF -> RESET_PC, kill/buffer cleared, IF/ID bubble; imem_req=0 while rst high. The instruction memory shares rst, so no pre-reset response arrives.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, InstrD 0, PCD 0, PCPlus4D 0, ValidD 0, FetchBusyF 0.
- Minimum fetch latency: req+gnt cycle N, rvalid cycle N+1, ValidD=1 from cycle N+2.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- One request outstanding at most; imem_rvalid outside WAIT is a protocol error (ignored).
- IF/ID outputs are registered; imem_req and imem_addr are decoded from registered state only.

## Structure
- Shared package riscv_pkg: XLEN, RESET_PC default, BUBBLE_INSTR = 32'h0000_0000, fetch-state enum.
- Sub-module if_id_reg: IF/ID register with load, stall and flush inputs; fetch_unit contains the FSM, PCF, kill flag and hold buffer.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory -> addresses 0x100, 0x104, 0x108 issued; ValidD pulses every 2 cycles with PCD matching.
- StallD high for 3 cycles while response arrives -> state HOLD, IF/ID unchanged, no new imem_req; word delivered the cycle after StallD falls.
- PCSrcE with PCTargetE=32'h203 in WAIT, rvalid 2 cycles later -> stale word discarded, next imem_addr=0x200, ValidD stays 0.
- PCSrcE and rvalid in same cycle -> no delivery, next request at target.
- FlushD with StallD -> ValidD=0, InstrD=0 the next cycle.
- PCF=32'hFFFF_FFFC fetched -> next imem_addr=0; rst asserted mid-WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions used by the fetch stage and the IF/ID register.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats stall, idle inserts a bubble.
module if_id_reg #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);
    import riscv_pkg::*;

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            valid_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            instr_q    <= XLEN'(BUBBLE_INSTR);
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_i + XLEN'(4);
            valid_q    <= 1'b1;
        end else if (!stall_i) begin
            // PC fields keep their last value; only the word and valid bit bubble.
            instr_q <= XLEN'(BUBBLE_INSTR);
            valid_q <= 1'b0;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake, hold buffer
// for stalled responses, kill tracking for redirected in-flight requests.
module fetch_unit #(
    parameter int unsigned XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusyF
);
    import riscv_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    logic            load_c;
    logic [XLEN-1:0] load_instr_c;
    logic [XLEN-1:0] load_pc_c;
    logic [XLEN-1:0] redirect_pc_c;
    logic [XLEN-1:0] pcf_plus4_c;
    logic            unused_target_lsb_c;

    assign redirect_pc_c       = {PCTargetE[XLEN-1:2], 2'b00};
    assign pcf_plus4_c         = pcf_q + XLEN'(4);
    assign unused_target_lsb_c = ^PCTargetE[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_REQ;
            pcf_q        <= RESET_PC;
            kill_q       <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Next-state, PC update and IF/ID load decision; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        load_c       = 1'b0;
        load_instr_c = imem_rdata;
        load_pc_c    = pcf_q;

        unique case (state_q)
            FETCH_REQ: begin
                if (imem_gnt) begin
                    state_d = FETCH_WAIT;
                    kill_d  = PCSrcE;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || PCSrcE) begin
                        kill_d  = 1'b0;
                        state_d = FETCH_REQ;
                    end else if (!StallD && !FlushD) begin
                        load_c  = 1'b1;
                        pcf_d   = pcf_plus4_c;
                        state_d = FETCH_REQ;
                    end else begin
                        // Decode busy or flushing: park the word until it can be taken.
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pcf_q;
                        state_d      = FETCH_HOLD;
                    end
                end else if (PCSrcE) begin
                    kill_d = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (PCSrcE) begin
                    state_d = FETCH_REQ;
                end else if (!StallD && !FlushD) begin
                    load_c       = 1'b1;
                    load_instr_c = hold_instr_q;
                    load_pc_c    = hold_pc_q;
                    pcf_d        = pcf_plus4_c;
                    state_d      = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        if (PCSrcE) begin
            pcf_d  = redirect_pc_c;
            load_c = 1'b0;
        end
    end

    assign imem_req   = (state_q == FETCH_REQ) && !rst;
    assign imem_addr  = pcf_q;
    assign FetchBusyF = (state_q == FETCH_WAIT);

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .stall_i    (StallD),
        .flush_i    (FlushD),
        .instr_i    (load_instr_c),
        .pc_i       (load_pc_c),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a bench-side instruction memory and a
// scoreboard of expected IF/ID deliveries.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusyF;

    int n_cmp = 0;
    int n_err = 0;

    // memory model / reference state
    logic        gnt_en;
    int          lat;
    logic        pend;
    logic        pend_stale;
    int          wait_cnt;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    logic [31:0] sb_instr[$];
    logic [31:0] sb_pc[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .FetchBusyF  (FetchBusyF)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory handshake, advance, update model, check deliveries.
    task automatic tick();
        logic        gnt_now, rv_now, st_prev;
        logic [31:0] e_instr, e_pc;
        #1;
        gnt_now     = !rst && gnt_en && imem_req && !pend;
        rv_now      = !rst && pend && (wait_cnt == 0);
        imem_gnt    = gnt_now;
        imem_rvalid = rv_now;
        imem_rdata  = rv_now ? word_of(pend_addr) : 32'h0;
        if (pend && !rst) chk("single_outstanding", 32'(imem_req), 32'd0);
        if (gnt_now) chk("grant_addr", imem_addr, exp_pc);
        st_prev = StallD;
        @(posedge clk);
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (rst) begin
            pend   = 1'b0;
            exp_pc = RST_PC;
            sb_instr.delete();
            sb_pc.delete();
        end else begin
            if (rv_now) begin
                if (!(pend_stale || PCSrcE)) begin
                    sb_instr.push_back(word_of(pend_addr));
                    sb_pc.push_back(pend_addr);
                    exp_pc = pend_addr + 32'd4;
                end
                pend = 1'b0;
            end else if (pend) begin
                wait_cnt--;
                pend_stale = pend_stale | PCSrcE;
            end
            if (gnt_now) begin
                pend       = 1'b1;
                pend_addr  = exp_pc;
                wait_cnt   = lat - 1;
                pend_stale = PCSrcE;
            end
            if (PCSrcE) exp_pc = {PCTargetE[31:2], 2'b00};
            if (ValidD && !st_prev) begin
                if (sb_pc.size() == 0) begin
                    chk("spurious_valid", 32'(ValidD), 32'd0);
                end else begin
                    e_instr = sb_instr.pop_front();
                    e_pc    = sb_pc.pop_front();
                    chk("deliver_instr", InstrD, e_instr);
                    chk("deliver_pc", PCD, e_pc);
                    chk("deliver_pc4", PCPlus4D, e_pc + 32'd4);
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for a fresh grant (pend becomes 1 on the grant cycle).
    task automatic wait_grant();
        for (int i = 0; i < 20 && pend; i++) tick();
        for (int i = 0; i < 20 && !pend; i++) tick();
        chk("wait_grant", 32'(pend), 32'd1);
    endtask

    task automatic chk_reset();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_ValidD", 32'(ValidD), 32'd0);
        chk("rst_FetchBusyF", 32'(FetchBusyF), 32'd0);
    endtask

    initial begin
        rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        gnt_en = 1'b1; lat = 1; pend = 1'b0; pend_stale = 1'b0; wait_cnt = 0;
        pend_addr = 32'h0; exp_pc = RST_PC;

        ticks(2);
        chk_reset();
        rst = 1'b0;

        // zero-wait streaming from RESET_PC
        tick();
        chk("first_busy", 32'(FetchBusyF), 32'd1);
        tick();
        chk("first_valid", 32'(ValidD), 32'd1);
        ticks(6);

        // stall while the response arrives
        wait_grant();
        StallD = 1'b1;
        ticks(3);
        chk("hold_no_req", 32'(imem_req), 32'd0);
        chk("hold_not_busy", 32'(FetchBusyF), 32'd0);
        StallD = 1'b0;
        tick();
        chk("hold_drained", 32'(sb_pc.size()), 32'd0);
        ticks(2);

        // redirect while waiting; stale response arrives later
        lat = 3;
        wait_grant();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0203;
        tick();
        PCSrcE = 1'b0;
        ticks(2);
        chk("redir_no_valid", 32'(ValidD), 32'd0);
        chk("redir_addr", imem_addr, 32'h0000_0200);
        ticks(4);

        // redirect in the same cycle as the response
        lat = 2;
        wait_grant();
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
        tick();
        PCSrcE = 1'b0;
        chk("same_no_valid", 32'(ValidD), 32'd0);
        chk("same_addr", imem_addr, 32'h0000_0300);
        ticks(4);

        // flush with stall clears IF/ID
        lat = 1;
        for (int i = 0; i < 20 && !ValidD; i++) tick();
        chk("flush_pre_valid", 32'(ValidD), 32'd1);
        StallD = 1'b1; FlushD = 1'b1;
        tick();
        chk("flush_ValidD", 32'(ValidD), 32'd0);
        chk("flush_InstrD", InstrD, 32'h0);
        chk("flush_PCD", PCD, 32'h0);
        chk("flush_PCPlus4D", PCPlus4D, 32'h0);
        StallD = 1'b0; FlushD = 1'b0;
        ticks(4);

        // PC wrap at the top of the address space
        gnt_en = 1'b0;
        ticks(2);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
        tick();
        PCSrcE = 1'b0; gnt_en = 1'b1;
        chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
        ticks(2);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", PCPlus4D, 32'h0000_0000);
        ticks(3);

        // reset in the middle of an outstanding request
        lat = 3;
        wait_grant();
        tick();
        rst = 1'b1;
        tick();
        chk_reset();
        rst = 1'b0;
        lat = 1;
        ticks(8);

        gnt_en = 1'b0;
        ticks(4);
        chk("sb_empty", 32'(sb_pc.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
